// File: rtl/pen_capture_if.sv
// rtl/pen_capture_if.sv - pixel command handshake between pen_capture and the frame-buffer writer
//
// Purpose: groups the pixel command stream into one bundle.
// Signals:
//   cmd_valid  command pending (master -> slave)
//   cmd_ready  writer accepts the command this cycle (slave -> master)
//   cmd_row    target pixel row (master -> slave)
//   cmd_col    target pixel column (master -> slave)
//   cmd_op     00 paint red, 01 paint green, 10 erase (master -> slave)
interface pen_capture_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_row;
  logic [2:0] cmd_col;
  logic [1:0] cmd_op;

  modport master (output cmd_valid, output cmd_row, output cmd_col, output cmd_op,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_row, input  cmd_col, input  cmd_op,
                  output cmd_ready);
endinterface

// File: rtl/pen_capture.sv
// rtl/pen_capture.sv - light-pen hit qualifier and pixel command generator
//
// Purpose: synchronizes the light-pen detector, qualifies hits against the
// pixel currently lit by the matrix scanner, and turns hits into paint/erase
// commands or colour changes depending on the system mode.
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   pen_in       raw light-pen detector (asynchronous)
//   scan_strobe  one-cycle pulse starting a new pixel dwell
//   scan_row     pixel row being lit (valid with scan_strobe)
//   scan_col     pixel column being lit (valid with scan_strobe)
//   state        system mode (RST/SLEEP/LIGHT/DRAW/WRITE/ERASE/COLOR, 7 = RST)
//   color_sel    current paint colour, 0 red, 1 green
//   drop_cnt     saturating count of hits lost to back-pressure
//   cmd          pixel command handshake (master side)
module pen_capture #(
  parameter int QUAL_N = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pen_in,
  input  logic                scan_strobe,
  input  logic [2:0]          scan_row,
  input  logic [2:0]          scan_col,
  input  logic [2:0]          state,
  output logic                color_sel,
  output logic [7:0]          drop_cnt,
  pen_capture_if.master       cmd
);

  localparam logic [2:0] ST_RST   = 3'd0;
  localparam logic [2:0] ST_DRAW  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_ERASE = 3'd5;
  localparam logic [2:0] ST_COLOR = 3'd6;
  localparam logic [2:0] ST_ALT_RST = 3'd7;

  localparam logic [3:0] QUAL_LAST = 4'(QUAL_N - 1);
  localparam logic [3:0] QUAL_MAX  = 4'(QUAL_N);

  logic       r_pen_meta;
  logic       r_pen_s;
  logic [3:0] r_qual_cnt;
  logic       r_hit_done;
  logic [2:0] r_pos_row;
  logic [2:0] r_pos_col;
  logic       r_cmd_valid;
  logic [2:0] r_cmd_row;
  logic [2:0] r_cmd_col;
  logic [1:0] r_cmd_op;
  logic       r_color_sel;
  logic [7:0] r_drop_cnt;
  logic       r_last_ok;
  logic [7:0] r_last;        // {row, col, op} of the last accepted command

  logic       w_soft;
  logic       w_hit;
  logic       w_cmd_hit;
  logic [1:0] w_op;
  logic       w_accept;
  logic       w_last_ok;
  logic [7:0] w_last;
  logic       w_dup;

  assign w_soft   = (state == ST_RST) || (state == ST_ALT_RST);
  // The strobe cycle ignores pen_s, so a qualifying sample coincident with a
  // strobe never produces a hit.
  assign w_hit    = !w_soft && !scan_strobe && r_pen_s && !r_hit_done &&
                    (r_qual_cnt == QUAL_LAST);
  assign w_cmd_hit = w_hit && ((state == ST_DRAW) || (state == ST_WRITE) ||
                               (state == ST_ERASE));
  assign w_op     = (state == ST_ERASE) ? 2'b10 : {1'b0, r_color_sel};
  assign w_accept = r_cmd_valid && cmd.cmd_ready;
  // A command accepted on this very edge already counts as the last accepted
  // one when screening a simultaneous hit for duplicates.
  assign w_last_ok = w_accept || r_last_ok;
  assign w_last    = w_accept ? {r_cmd_row, r_cmd_col, r_cmd_op} : r_last;
  assign w_dup     = w_last_ok && (w_last == {r_pos_row, r_pos_col, w_op});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pen_meta  <= 1'b0;
      r_pen_s     <= 1'b0;
      r_qual_cnt  <= 4'd0;
      r_hit_done  <= 1'b0;
      r_pos_row   <= 3'd0;
      r_pos_col   <= 3'd0;
      r_cmd_valid <= 1'b0;
      r_cmd_row   <= 3'd0;
      r_cmd_col   <= 3'd0;
      r_cmd_op    <= 2'b00;
      r_color_sel <= 1'b0;
      r_drop_cnt  <= 8'd0;
      r_last_ok   <= 1'b0;
      r_last      <= 8'd0;
    end else begin
      r_pen_meta <= pen_in;
      r_pen_s    <= r_pen_meta;

      if (scan_strobe) begin
        r_pos_row <= scan_row;
        r_pos_col <= scan_col;
      end

      if (w_soft) begin
        // Mode RST clears the capture path; colour and drop count survive.
        r_qual_cnt  <= 4'd0;
        r_hit_done  <= 1'b0;
        r_cmd_valid <= 1'b0;
        r_last_ok   <= 1'b0;
      end else begin
        if (scan_strobe) begin
          r_qual_cnt <= 4'd0;
          r_hit_done <= 1'b0;
        end else if (!r_pen_s) begin
          r_qual_cnt <= 4'd0;
        end else if (r_qual_cnt < QUAL_MAX) begin
          r_qual_cnt <= r_qual_cnt + 4'd1;
        end

        if (w_hit) begin
          r_hit_done <= 1'b1;
        end

        if (w_accept) begin
          r_last_ok   <= 1'b1;
          r_last      <= {r_cmd_row, r_cmd_col, r_cmd_op};
          r_cmd_valid <= 1'b0;
        end

        if (w_cmd_hit && !w_dup) begin
          if (r_cmd_valid && !cmd.cmd_ready) begin
            if (r_drop_cnt != 8'hFF) begin
              r_drop_cnt <= r_drop_cnt + 8'd1;
            end
          end else begin
            r_cmd_valid <= 1'b1;
            r_cmd_row   <= r_pos_row;
            r_cmd_col   <= r_pos_col;
            r_cmd_op    <= w_op;
          end
        end

        if (w_hit && (state == ST_COLOR)) begin
          r_color_sel <= !r_color_sel;
        end
      end
    end
  end

  assign cmd.cmd_valid = r_cmd_valid;
  assign cmd.cmd_row   = r_cmd_row;
  assign cmd.cmd_col   = r_cmd_col;
  assign cmd.cmd_op    = r_cmd_op;
  assign color_sel     = r_color_sel;
  assign drop_cnt      = r_drop_cnt;

endmodule
